// File: rtl/sha_hex_tx.sv
// Streams a captured digest to a byte-wide UART transmitter as lowercase hex,
// most-significant nibble first, with an optional CR/LF terminator.
module sha_hex_tx #(
    parameter int unsigned NIBBLES = 64,
    parameter bit          TERM    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] digest,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DIGEST_W = 4 * NIBBLES;
    localparam int unsigned LEN      = TERM ? NIBBLES + 2 : NIBBLES;
    localparam int unsigned IW       = $clog2(NIBBLES + 3);
    localparam logic [IW-1:0] IDX_NIB  = IW'(NIBBLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, FINISH} state_t;

    state_t              state, state_nx;
    logic [DIGEST_W-1:0] shreg;
    logic [IW-1:0]       idx;
    logic [3:0]          tmo;
    logic [3:0]          nib;
    logic [7:0]          cur_byte;
    logic [7:0]          last_byte;
    logic                send_now;

    always_comb begin
        nib = shreg[DIGEST_W-1 -: 4];
        if (idx < IDX_NIB)
            cur_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
        else if (idx == IDX_NIB)
            cur_byte = 8'h0D;
        else
            cur_byte = 8'h0A;
    end

    // Gated by rst_n so a reset cycle can never launch another byte.
    assign send_now = rst_n && (state == SEND) && !tx_busy;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            idx       <= '0;
            tmo       <= '0;
            last_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= digest;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        last_byte <= cur_byte;
                        shreg     <= shreg << 4;
                        tmo       <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!tx_busy)
                        tmo <= tmo + 1'b1;
                end
                WAIT_LO: begin
                    if (!tx_busy && idx != IDX_LAST)
                        idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEND;
            SEND:    if (!tx_busy) state_nx = WAIT_HI;
            WAIT_HI: if (tx_busy || tmo == 4'd15) state_nx = WAIT_LO;
            WAIT_LO: begin
                if (!tx_busy)
                    state_nx = (idx == IDX_LAST) ? FINISH : SEND;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Between sends tx_data shows the last byte launched, so it stays stable.
    always_comb begin
        tx_send = send_now;
        tx_data = send_now ? cur_byte : last_byte;
        busy    = (state == SEND) || (state == WAIT_HI) || (state == WAIT_LO);
        done    = (state == FINISH);
    end

endmodule

// File: tb/tb_sha_hex_tx.sv
// Bench for sha_hex_tx: a TERM=1 and a TERM=0 instance, a busy-flag transmitter
// model, and a digest-to-ASCII reference built from the hex/terminator rules.
module tb_sha_hex_tx;

    localparam int unsigned NIB = 64;
    localparam int unsigned W   = 4 * NIB;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start;
    logic [W-1:0]     digest;
    logic [1:0]       tx_send;
    logic [1:0][7:0]  tx_data;
    logic [1:0]       tx_busy;
    logic [1:0]       busy;
    logic [1:0]       done;

    always #5 clk = ~clk;

    sha_hex_tx #(.NIBBLES(NIB), .TERM(1'b1)) u_term (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .digest(digest),
        .tx_send(tx_send[0]), .tx_data(tx_data[0]), .tx_busy(tx_busy[0]),
        .busy(busy[0]), .done(done[0])
    );

    sha_hex_tx #(.NIBBLES(NIB), .TERM(1'b0)) u_noterm (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .digest(digest),
        .tx_send(tx_send[1]), .tx_data(tx_data[1]), .tx_busy(tx_busy[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Transmitter model: busy for busy_len cycles after each accepted byte.
    int unsigned busy_len   = 10;
    bit          never_busy = 1'b0;
    bit          force_busy = 1'b0;
    int unsigned cnt [2];

    initial begin
        cnt[0] = 0;
        cnt[1] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tx_send[i] && !never_busy)
                cnt[i] <= busy_len;
            else if (cnt[i] != 0)
                cnt[i] <= cnt[i] - 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++)
            tx_busy[i] = force_busy || (cnt[i] != 0);
    end

    // Monitor: collects bytes, send times, done pulses and protocol errors.
    logic [7:0]  rxq [$];
    int unsigned sendcyc [$];
    int unsigned done_cnt  = 0;
    int unsigned proto_err = 0;
    int unsigned stab_err  = 0;
    int unsigned cyc       = 0;
    bit          mon_en    = 1'b0;
    logic [7:0]  held [2];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (tx_send[i]) begin
                    rxq.push_back(tx_data[i]);
                    sendcyc.push_back(cyc);
                    if (tx_busy[i]) proto_err = proto_err + 1;
                    held[i] = tx_data[i];
                end else if (tx_data[i] !== held[i]) begin
                    stab_err = stab_err + 1;
                end
                if (!rst_n) held[i] = 8'h00;
                if (done[i]) done_cnt = done_cnt + 1;
            end
        end else begin
            held[0] = 8'h00;
            held[1] = 8'h00;
        end
    end

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: each nibble from the top becomes '0'-'9' or 'a'-'f'.
    logic [7:0] expq [$];

    function automatic void build_exp(input logic [W-1:0] d, input bit term);
        logic [W-1:0] t;
        int           n;
        expq.delete();
        for (int i = 0; i < NIB; i++) begin
            t = d >> (4 * (NIB - 1 - i));
            n = int'(t[3:0]);
            expq.push_back(8'(n < 10 ? 48 + n : 97 + n - 10));
        end
        if (term) begin
            expq.push_back(8'h0D);
            expq.push_back(8'h0A);
        end
    endfunction

    function automatic logic [W-1:0] rand_digest();
        logic [W-1:0] d;
        for (int j = 0; j < W / 32; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    task automatic run_msg(input string tag, input int inst, input logic [W-1:0] d,
                           input int repulse_at, input int hold_busy, input int rst_at,
                           input bit chk_gap);
        int unsigned base_q, base_d, base_s, k, busy_low, min_gap;
        bit rp;
        build_exp(d, inst == 0);
        base_q   = rxq.size();
        base_s   = sendcyc.size();
        base_d   = done_cnt;
        busy_low = 0;
        rp       = 1'b0;
        k        = 0;
        if (hold_busy > 0) force_busy = 1'b1;
        digest     = d;
        start[inst] = 1'b1;
        tick();
        start[inst] = 1'b0;
        digest     = rand_digest();
        if (hold_busy > 0) begin
            repeat (hold_busy - 1) tick();
            check({tag, "_held_nosend"}, 64'(rxq.size() - base_q), 64'd0);
            force_busy = 1'b0;
        end
        while (done_cnt == base_d && k < 4000) begin
            if (busy[inst] !== 1'b1 && done[inst] !== 1'b1) busy_low++;
            if (rst_at >= 0 && rxq.size() - base_q == rst_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                check({tag, "_rst_busy"}, 64'(busy[inst]), 64'd0);
                check({tag, "_rst_send"}, 64'(tx_send[inst]), 64'd0);
                check({tag, "_rst_data"}, 64'(tx_data[inst]), 64'h00);
                repeat (60) tick();
                check({tag, "_rst_nomore"}, 64'(rxq.size() - base_q), 64'(rst_at));
                check({tag, "_rst_nodone"}, 64'(done_cnt - base_d), 64'd0);
                return;
            end
            if (repulse_at >= 0 && !rp && rxq.size() - base_q == repulse_at) begin
                digest      = ~d;
                start[inst] = 1'b1;
                rp          = 1'b1;
            end
            tick();
            start[inst] = 1'b0;
            k++;
        end
        check({tag, "_done_in_time"}, 64'(done_cnt != base_d), 64'd1);
        repeat (30) tick();
        check({tag, "_done_once"}, 64'(done_cnt - base_d), 64'd1);
        check({tag, "_len"}, 64'(rxq.size() - base_q), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            if (base_q + i < rxq.size())
                check($sformatf("%s_b%0d", tag, i), 64'(rxq[base_q + i]), 64'(expq[i]));
        check({tag, "_busy_held"}, 64'(busy_low), 64'd0);
        check({tag, "_no_send_while_busy"}, 64'(proto_err), 64'd0);
        check({tag, "_data_stable"}, 64'(stab_err), 64'd0);
        if (chk_gap) begin
            min_gap = 32'hFFFF_FFFF;
            for (int i = base_s + 1; i < sendcyc.size(); i++)
                if (sendcyc[i] - sendcyc[i-1] < min_gap) min_gap = sendcyc[i] - sendcyc[i-1];
            check({tag, "_timeout_gap_ge17"}, 64'(min_gap >= 17), 64'd1);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = '0;
        digest = '0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_send%0d", i), 64'(tx_send[i]), 64'd0);
            check($sformatf("reset_data%0d", i), 64'(tx_data[i]), 64'h00);
            check($sformatf("reset_busy%0d", i), 64'(busy[i]), 64'd0);
            check($sformatf("reset_done%0d", i), 64'(done[i]), 64'd0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        run_msg("pattern", 0, {4{64'h0123456789abcdef}}, -1, 0, -1, 1'b0);
        run_msg("ones",    0, '1, -1, 0, -1, 1'b0);
        run_msg("zeros",   0, '0, -1, 0, -1, 1'b0);
        run_msg("noterm",  1, rand_digest(), -1, 0, -1, 1'b0);
        run_msg("repulse", 0, rand_digest(), 5, 0, -1, 1'b0);
        run_msg("heldbusy", 0, '0, -1, 50, -1, 1'b0);
        run_msg("midreset", 0, rand_digest(), -1, 0, 10, 1'b0);
        run_msg("after_rst", 0, rand_digest(), -1, 0, -1, 1'b0);
        never_busy = 1'b1;
        run_msg("timeout", 0, rand_digest(), -1, 0, -1, 1'b1);
        never_busy = 1'b0;
        for (int r = 0; r < 4; r++) begin
            busy_len = $urandom_range(1, 12);
            run_msg($sformatf("rand%0d", r), int'($urandom_range(0, 1)), rand_digest(),
                    -1, 0, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha_hex_tx.md
SHA_HEX_TX -- requirements
Module: sha_hex_tx

Interface
REQ-001 Parameter NIBBLES, default 64: number of hex characters emitted per digest (4 bits each, taken from the DIGEST_W = 4*NIBBLES LSBs).
REQ-002 Parameter TERM, default 1: 1 = append CR (0x0D) then LF (0x0A) after the hex characters; 0 = no terminator.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous reset, active-low.
REQ-005 start  in  1  request to transmit digest; sampled only in IDLE.
REQ-006 digest  in  4*NIBBLES  hash value; captured on accepted start.
REQ-007 tx_send  out  1  one-cycle byte strobe to the UART transmitter.
REQ-008 tx_data  out  8  byte to the UART transmitter; valid while tx_send=1.
REQ-009 tx_busy  in  1  UART transmitter busy flag.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse after the final byte completes.

Function
REQ-012 States: IDLE, SEND, WAIT_HI, WAIT_LO, FINISH.
REQ-013 IDLE: start=1 -> capture digest into a shift register and clear the byte index -> SEND; start=0 -> stay in IDLE.
REQ-014 start asserted in any state other than IDLE is ignored; the captured digest never changes mid-message.
REQ-015 SEND: if tx_busy=0, assert tx_send=1 for exactly one cycle with tx_data = current byte -> WAIT_HI; if tx_busy=1, hold tx_send=0 and stay in SEND.
REQ-016 WAIT_HI: stay until tx_busy=1, then -> WAIT_LO; a 16-cycle timeout with no rise also -> WAIT_LO, so a missed busy edge cannot hang the block.
REQ-017 WAIT_LO: stay until tx_busy=0; then, if bytes remain, advance the index -> SEND, else -> FINISH.
REQ-018 Byte order: most-significant nibble of the digest first; shift the register left by 4 per hex character.
REQ-019 Hex mapping: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x61+(n-10) (lowercase a-f).
REQ-020 Message length: NIBBLES+2 bytes if TERM=1, else NIBBLES; the index counter is sized to hold NIBBLES+2 without wrap.
REQ-021 FINISH: done=1 for one cycle -> IDLE; busy drops the same cycle done is asserted.
REQ-022 At most one tx_send pulse per byte; never assert tx_send while tx_busy=1.
REQ-023 tx_data is held stable from its tx_send cycle until the next tx_send.

Reset
REQ-024 rst_n=0 at a clock edge -> state IDLE; tx_send=0, tx_data=0x00, busy=0, done=0; index, timeout counter and shift register cleared.
REQ-025 Reset mid-message aborts the message with no further tx_send; a byte already in flight in the transmitter is not recalled; a later start restarts at byte 0.
REQ-026 rst_n has priority over start in the same cycle.

Verification
REQ-027 Transmitter model busy 10 cycles after each send; digest = 0123456789abcdef repeated 4x, TERM=1, start -> 66 tx_send pulses: "0123456789abcdef" x4, then 0x0D, 0x0A; exactly one done pulse; busy high throughout.
REQ-028 digest all-ones -> 64 bytes of 0x66; digest all-zeros -> 64 bytes of 0x30; TERM=0 -> exactly 64 bytes, no 0x0D/0x0A.
REQ-029 start re-pulsed during byte 5 with a different digest -> output unchanged from the first digest; no second done.
REQ-030 tx_busy held high for 50 cycles when start is accepted -> tx_send stays 0 until tx_busy falls, then the first byte is 0x30 for digest 0.
REQ-031 rst_n=0 for one cycle after the 10th tx_send -> next cycle busy=0, tx_send=0; no further bytes; a subsequent start emits the full message from byte 0.
REQ-032 Transmitter model that never raises busy -> each byte advances after the 16-cycle timeout; 66 bytes, then done.
